// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// The parity helper lets the top level precompute the parity bit at byte capture.
package fifo_uart_pkg;

    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } txState_e;

    function automatic logic calcParity(input logic [DATA_W-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses bitDone_o on the last count.
// Holding clear_i keeps the counter at zero so the next bit starts on a full period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic bitDone_o
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bitDone_o = !clear_i && (count_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends each as an LSB-first UART frame
// with optional parity, counting completed frames.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int               IDX_W     = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    txState_e          state_q, state_d;
    logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
    logic [IDX_W-1:0]  bitIdx_q, bitIdx_d;
    logic              parityBit_q, parityBit_d;
    logic              tx_q, tx_d;
    logic [15:0]       frames_q, frames_d;

    logic bitDone;
    logic timerClear;
    logic popReq;
    logic lastStopCycle;

    assign timerClear    = (state_q == IDLE) || (state_q == WAIT);
    assign lastStopCycle = (state_q == STOP) && bitDone && (bitIdx_q == LAST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) bitTimer (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (timerClear),
        .bitDone_o(bitDone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            bitIdx_q    <= '0;
            parityBit_q <= 1'b0;
            tx_q        <= 1'b1;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            shiftReg_q  <= shiftReg_d;
            bitIdx_q    <= bitIdx_d;
            parityBit_q <= parityBit_d;
            tx_q        <= tx_d;
            frames_q    <= frames_d;
        end
    end

    // tx_d is only changed on bit boundaries, so the line is a clean register output.
    always_comb begin
        state_d     = state_q;
        shiftReg_d  = shiftReg_q;
        bitIdx_d    = bitIdx_q;
        parityBit_d = parityBit_q;
        tx_d        = tx_q;
        frames_d    = frames_q;
        case (state_q)
            IDLE: begin
                if (popReq) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                shiftReg_d  = fifo_data;
                parityBit_d = calcParity(fifo_data, PARITY_ODD != 0);
                tx_d        = 1'b0;
                state_d     = START;
            end
            START: begin
                if (bitDone) begin
                    tx_d    = shiftReg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitDone) begin
                    shiftReg_d = shiftReg_q >> 1;
                    if (bitIdx_q == LAST_DATA) begin
                        bitIdx_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parityBit_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                        tx_d     = shiftReg_q[1];
                    end
                end
            end
            PARITY: begin
                if (bitDone) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (lastStopCycle) begin
                    bitIdx_d = '0;
                    frames_d = frames_q + 16'd1;
                    state_d  = popReq ? WAIT : IDLE;
                end else if (bitDone) begin
                    bitIdx_d = bitIdx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pops happen only from IDLE or on the final stop cycle, never while empty or in reset.
    always_comb begin
        popReq = 1'b0;
        busy   = (state_q != IDLE);
        if (!rst && en && !fifo_empty) begin
            if ((state_q == IDLE) || lastStopCycle) begin
                popReq = 1'b1;
            end
        end
    end

    assign fifo_rd_en  = popReq;
    assign tx          = tx_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Drives three transmitter variants (no parity, even, odd) from per-lane FIFO models
// and decodes the serial line against frames predicted from each popped byte.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  en = 1'b1;
    int    cycle = 0;
    int    checks = 0;
    int    passes = 0;
    logic  idleReq = 1'b0;
    string idleTag = "";

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input int ln, input string nm, input logic [63:0] got,
                               input logic [63:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL lane%0d %s: got %0h, expected %0h", ln, nm, got, want);
        end
    endtask

    // Expected line level for every clock of a frame: start, 8 data bits LSB first,
    // optional parity, stop.  Bit c of the result is the level during frame cycle c.
    function automatic logic [63:0] frameWave(input logic [7:0] b, input int parEn,
                                              input int parOdd);
        logic [63:0] w;
        int          ones;
        int          nbits;
        int          k;
        logic        lvl;
        w     = '0;
        ones  = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        nbits = (parEn != 0) ? 11 : 10;
        for (int c = 0; c < nbits * C; c++) begin
            k = c / C;
            if (k == 0)                      lvl = 1'b0;
            else if (k <= 8)                 lvl = b[k-1];
            else if (parEn != 0 && k == 9)   lvl = (parOdd != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            else                             lvl = 1'b1;
            w[c] = lvl;
        end
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int PE   = (g == 0) ? 0 : 1;
        localparam int PO   = (g == 2) ? 1 : 0;
        localparam int FLEN = ((PE != 0) ? 11 : 10) * C;

        logic        fifoEmpty = 1'b1;
        logic [7:0]  fifoData = '0;
        logic        rdEn;
        logic        tx;
        logic        busy;
        logic [15:0] frames;

        logic [7:0]  fifoQ[$];
        logic [63:0] expWave[$];
        int          expPop[$];
        int          lastPop = 0;
        int          framesExp = 0;
        int          mPos = -1;
        logic [63:0] got = '0;
        logic [63:0] want = '0;

        fifo_uart_tx #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .fifo_empty (fifoEmpty),
            .fifo_data  (fifoData),
            .fifo_rd_en (rdEn),
            .tx         (tx),
            .busy       (busy),
            .frames_sent(frames)
        );

        // FIFO read side: a pop sampled on this edge presents the head byte from it onward.
        initial forever begin
            @(posedge clk);
            if (rdEn) begin
                checkOutput(g, "pop with empty flag set", fifoEmpty, 0);
                checkOutput(g, "pop during reset", rst, 0);
                if (busy) checkOutput(g, "back-to-back pop period", cycle - lastPop, FLEN + 1);
                lastPop = cycle;
                if (fifoQ.size() != 0) begin
                    fifoData <= fifoQ[0];
                    expWave.push_back(frameWave(fifoQ[0], PE, PO));
                    expPop.push_back(cycle);
                    void'(fifoQ.pop_front());
                end
            end
        end

        // Line monitor: a falling tx starts a frame, which is sampled every clock.
        initial forever begin
            @(negedge clk);
            fifoEmpty = (fifoQ.size() == 0);
            if (idleReq) begin
                checkOutput(g, {idleTag, " tx"}, tx, 1);
                checkOutput(g, {idleTag, " busy"}, busy, 0);
                checkOutput(g, {idleTag, " fifo_rd_en"}, rdEn, 0);
                checkOutput(g, {idleTag, " frames_sent"}, frames, 16'(framesExp));
            end
            if (rst) begin
                mPos      = -1;
                framesExp = 0;
                expWave.delete();
                expPop.delete();
            end else if (mPos == FLEN) begin
                checkOutput(g, "frames_sent after frame", frames, 16'(framesExp));
                mPos = -1;
            end else if (mPos >= 0) begin
                got[mPos] = tx;
                mPos++;
                if (mPos == FLEN) begin
                    checkOutput(g, "frame waveform", got, want);
                    framesExp++;
                end
            end else if (tx == 1'b0) begin
                if (expWave.size() == 0) begin
                    checkOutput(g, "start bit without pop", 1, 0);
                end else begin
                    want = expWave.pop_front();
                    checkOutput(g, "pop-to-start latency", cycle - expPop.pop_front(), 2);
                    got  = '0;
                    mPos = 1;
                end
            end
        end
    end

    function automatic bit allIdle();
        return lane[0].fifoQ.size() == 0 && lane[1].fifoQ.size() == 0 &&
               lane[2].fifoQ.size() == 0 && !lane[0].busy && !lane[1].busy &&
               !lane[2].busy && lane[0].mPos == -1 && lane[1].mPos == -1 &&
               lane[2].mPos == -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        lane[0].fifoQ.push_back(b);
        lane[1].fifoQ.push_back(b);
        lane[2].fifoQ.push_back(b);
    endtask

    task automatic requestIdleCheck(input string tag);
        idleTag = tag;
        idleReq = 1'b1;
        @(negedge clk);
        #1;
        idleReq = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!allIdle() && n < 3000);
        checkOutput(0, {tag, " drained in time"}, n < 3000, 1);
        tick(1);
    endtask

    task automatic waitStart(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lane[0].tx !== 1'b0 && n < 100);
        checkOutput(0, {tag, " start bit seen"}, n < 100, 1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        tick(3);
        rst = 1'b0;
        requestIdleCheck("after reset");

        // Abort a frame during data bit 3 (start is 4 clocks, each data bit 4 clocks).
        applyStimulus(8'h5A);
        waitStart("mid-frame reset");
        tick(16);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        requestIdleCheck("after mid-frame reset");

        applyStimulus(8'hA5);
        waitIdle("single A5");
        requestIdleCheck("after single frame");

        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        waitIdle("back-to-back");
        requestIdleCheck("after back-to-back");

        applyStimulus(8'h81);
        applyStimulus(8'h42);
        applyStimulus(8'h99);
        waitStart("en drop");
        tick(2 * C);
        en = 1'b0;
        tick(60);
        requestIdleCheck("en held low");
        checkOutput(0, "bytes left queued", lane[0].fifoQ.size(), 2);
        checkOutput(1, "bytes left queued", lane[1].fifoQ.size(), 2);
        checkOutput(2, "bytes left queued", lane[2].fifoQ.size(), 2);
        en = 1'b1;
        waitIdle("en restored");

        for (int i = 0; i < 25; i++) begin
            int nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) applyStimulus(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, 30));
                en = 1'b0;
                tick($urandom_range(1, 60));
                en = 1'b1;
            end
            tick($urandom_range(0, 80));
        end
        waitIdle("random");
        requestIdleCheck("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
